// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the 60-bit SPI frame initiator.
package spi_pkg;

  localparam int SPI_FRAME_BITS  = 60;
  localparam int SPI_CLK_DIV_MIN = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period counter: reloads to CLK_DIV-1 on load, counts down, flags terminal count at zero.
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic tc
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RELOAD;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 frame initiator: shifts tx_data out MSB-first, captures SPI_SDO, checks the SPI_LDB load strobe.
module spi_master
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = SPI_FRAME_BITS,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  ldb_err,
  output logic                  SPI_CSB,
  output logic                  SPI_CLK,
  output logic                  SPI_SDI,
  input  logic                  SPI_SDO,
  input  logic                  SPI_LDB,
  output logic [2:0]            state_dbg
);

  localparam int IW  = $clog2(FRAME_BITS);
  localparam int DIV = (CLK_DIV < SPI_CLK_DIV_MIN) ? SPI_CLK_DIV_MIN : CLK_DIV;

  spi_state_t            state;
  logic [FRAME_BITS-1:0] tx_reg;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [IW-1:0]         bit_idx;
  logic [IW-1:0]         nxt_idx;
  logic                  ldb_seen;
  logic                  tc;
  logic                  div_load;
  logic                  sdo_bit;

  // Every non-idle state exits on terminal count, so reloading there covers each state entry.
  assign div_load  = (state == ST_IDLE) || tc;
  assign nxt_idx   = bit_idx - IW'(1);
  assign state_dbg = state;

  // A floating SDO line reads as 0.
  always_comb begin
    sdo_bit = 1'b0;
    if (SPI_SDO == 1'b1) sdo_bit = 1'b1;
  end

  spi_sclk_div #(.CLK_DIV(DIV)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (div_load),
    .tc      (tc)
  );

  // Handshake: start is taken only in IDLE with busy low; busy rises the cycle after and
  // stays high through the done cycle. A start seen while busy is dropped, never queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      ldb_err  <= 1'b0;
      SPI_CSB  <= 1'b1;
      SPI_CLK  <= 1'b0;
      SPI_SDI  <= 1'b0;
      tx_reg   <= '0;
      rx_shift <= '0;
      bit_idx  <= '0;
      ldb_seen <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            tx_reg  <= tx_data;
            bit_idx <= IW'(FRAME_BITS - 1);
            busy    <= 1'b1;
            SPI_CSB <= 1'b0;
            SPI_CLK <= 1'b0;
            SPI_SDI <= tx_data[FRAME_BITS-1];
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tc) begin
            SPI_CLK           <= 1'b1;
            rx_shift[bit_idx] <= sdo_bit;
            state             <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tc) begin
            SPI_CLK <= 1'b0;
            SPI_SDI <= (bit_idx != '0) ? tx_reg[nxt_idx] : 1'b0;
            state   <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (tc) begin
            if (bit_idx == '0) begin
              SPI_CSB  <= 1'b1;
              SPI_SDI  <= 1'b0;
              ldb_seen <= 1'b0;
              state    <= ST_GAP;
            end else begin
              SPI_CLK           <= 1'b1;
              bit_idx           <= nxt_idx;
              rx_shift[nxt_idx] <= sdo_bit;
              state             <= ST_HIGH;
            end
          end
        end
        ST_GAP: begin
          if (!SPI_LDB) ldb_seen <= 1'b1;
          if (tc) begin
            done    <= 1'b1;
            rx_data <= rx_shift;
            ldb_err <= ~(ldb_seen | ~SPI_LDB);
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master paired with a behavioural 60-bit responder that echoes its previous frame.
`timescale 1ns/1ps
module tb_spi_master;
  import spi_pkg::*;

  localparam int FB  = SPI_FRAME_BITS;
  localparam int DIV = 4;
  localparam int LAT = DIV * (2 * FB + 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start = 1'b0;
  logic [FB-1:0] tx_data = '0;
  logic          busy, done, ldb_err;
  logic [FB-1:0] rx_data;
  logic          SPI_CSB, SPI_CLK, SPI_SDI, SPI_SDO, SPI_LDB;
  logic [2:0]    state_dbg;

  spi_master #(.FRAME_BITS(FB), .CLK_DIV(DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .tx_data   (tx_data),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .ldb_err   (ldb_err),
    .SPI_CSB   (SPI_CSB),
    .SPI_CLK   (SPI_CLK),
    .SPI_SDI   (SPI_SDI),
    .SPI_SDO   (SPI_SDO),
    .SPI_LDB   (SPI_LDB),
    .state_dbg (state_dbg)
  );

  // ---------------- responder model (reset = ~reset_n) ----------------
  logic [FB-1:0] slv_shift = '0;
  logic [FB-1:0] slv_data  = '0;
  int            slv_cnt   = 0;
  int            ldb_cnt   = 0;
  logic          slv_sdo   = 1'b0;
  logic          slv_ldb   = 1'b1;
  logic          ldb_hold  = 1'b0;
  logic          sl_csb_q  = 1'b1;
  logic          sl_clk_q  = 1'b0;

  assign SPI_SDO = SPI_CSB ? 1'b0 : slv_sdo;
  assign SPI_LDB = slv_ldb;

  always @(negedge clk) begin
    if (!reset_n) begin
      slv_shift = '0; slv_data = '0; slv_cnt = 0; ldb_cnt = 0;
      slv_sdo = 1'b0; slv_ldb = 1'b1; sl_csb_q = 1'b1; sl_clk_q = 1'b0;
    end else begin
      if (sl_csb_q && !SPI_CSB) begin
        slv_cnt = 0;
        slv_sdo = slv_data[FB-1];
      end
      if (!SPI_CSB && !sl_clk_q && SPI_CLK) begin
        slv_shift = {slv_shift[FB-2:0], SPI_SDI};
        slv_cnt++;
      end
      if (!SPI_CSB && sl_clk_q && !SPI_CLK && slv_cnt < FB) slv_sdo = slv_data[FB-1-slv_cnt];
      if (!sl_csb_q && SPI_CSB) begin
        slv_data = slv_shift;
        ldb_cnt  = 2;
      end
      slv_ldb = !(ldb_cnt > 0 && !ldb_hold);
      if (ldb_cnt > 0) ldb_cnt--;
      sl_csb_q = SPI_CSB;
      sl_clk_q = SPI_CLK;
    end
  end

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  logic [FB-1:0] exp_q[$];
  logic [FB-1:0] txq[$];
  logic          exp_ldb_err = 1'b0;
  int            accept_cyc = 0;

  task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int   edge_cnt = 0, sdi_viol = 0, csb_viol = 0, csb_high_run = 0, frames_seen = 0;
  logic csb_prev = 1'b1, clk_prev = 1'b0, sdi_prev = 1'b0;

  always @(negedge clk) begin
    logic [FB-1:0] e, t;
    if (!reset_n) begin
      edge_cnt = 0; sdi_viol = 0; csb_viol = 0; csb_high_run = 0; frames_seen = 0;
      csb_prev = 1'b1; clk_prev = 1'b0; sdi_prev = 1'b0;
    end else begin
      if (csb_prev && !SPI_CSB) begin
        if (frames_seen > 0) check_int("csb_gap_ok", int'(csb_high_run >= DIV + 1), 1);
        edge_cnt = 0; sdi_viol = 0; csb_viol = 0;
      end
      if (!clk_prev && SPI_CLK) begin
        edge_cnt++;
        if (SPI_SDI !== sdi_prev) sdi_viol++;
        if (SPI_CSB) csb_viol++;
      end
      csb_high_run = SPI_CSB ? csb_high_run + 1 : 0;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          t = txq.pop_front();
          check("rx_data", rx_data, e);
          check_int("ldb_err", int'(ldb_err), int'(exp_ldb_err));
          check_int("latency", cyc - accept_cyc, LAT);
          check_int("clk_edges", edge_cnt, FB);
          check_int("sdi_unstable", sdi_viol, 0);
          check_int("csb_high_in_frame", csb_viol, 0);
          check("slave_data", slv_data, t);
        end
        frames_seen++;
      end
      csb_prev = SPI_CSB; clk_prev = SPI_CLK; sdi_prev = SPI_SDI;
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a falling edge; holds start until the accept is visible as busy=1 outside a done cycle.
  task automatic send(input logic [FB-1:0] tx, input logic [FB-1:0] exp_rx, input logic exp_err);
    int n;
    start = 1'b1;
    tx_data = tx;
    n = 0;
    @(negedge clk);
    while (!(busy && !done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!(busy && !done)) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got busy=%0b expected busy=1", busy);
    end else begin
      accept_cyc  = cyc;
      exp_ldb_err = exp_err;
      exp_q.push_back(exp_rx);
      txq.push_back(tx);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < LAT + 50) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got done=0 expected done within %0d cycles", LAT + 50);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [FB-1:0] tx;
    logic [FB-1:0] exp_rx;
    logic          exp_err;
    logic          hold;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [FB-1:0] prev_tx, rnd, x_tx, y_tx, z_tx;
    int busy_seen, n;

    vecs[0] = '{60'hABC_DEF0_1234_5678, 60'h000_0000_0000_0000, 1'b0, 1'b0};
    vecs[1] = '{60'h0FF_00FF_00FF_00FF, 60'hABC_DEF0_1234_5678, 1'b0, 1'b0};
    vecs[2] = '{60'h5A5_A5A5_A5A5_A5A5, 60'h0FF_00FF_00FF_00FF, 1'b0, 1'b0};
    vecs[3] = '{60'hFFF_FFFF_FFFF_FFFF, 60'h5A5_A5A5_A5A5_A5A5, 1'b1, 1'b1};
    vecs[4] = '{60'h800_0000_0000_0001, 60'hFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[5] = '{60'h000_0000_0000_0000, 60'h800_0000_0000_0001, 1'b0, 1'b0};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_done", int'(done), 0);
    check("rst_rx_data", rx_data, '0);
    check_int("rst_ldb_err", int'(ldb_err), 0);
    check_int("rst_csb", int'(SPI_CSB), 1);
    check_int("rst_sclk", int'(SPI_CLK), 0);
    check_int("rst_sdi", int'(SPI_SDI), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      ldb_hold = vecs[i].hold;
      send(vecs[i].tx, vecs[i].exp_rx, vecs[i].exp_err);
      wait_done();
      @(negedge clk);
    end
    ldb_hold = 1'b0;
    prev_tx = vecs[5].tx;

    for (int i = 0; i < 4; i++) begin
      rnd = {$urandom, $urandom};
      send(rnd, prev_tx, 1'b0);
      wait_done();
      prev_tx = rnd;
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    // back-to-back start in the done cycle, then a request while busy that must be dropped
    x_tx = 60'h123_4567_89AB_CDEF;
    y_tx = 60'hFED_CBA9_8765_4321;
    z_tx = 60'h3C3_C3C3_C3C3_C3C3;
    send(x_tx, prev_tx, 1'b0);
    wait_done();
    send(y_tx, x_tx, 1'b0);
    repeat (100) @(negedge clk);
    start = 1'b1;
    tx_data = z_tx;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    busy_seen = 0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check_int("busy_request_dropped", busy_seen, 0);
    prev_tx = y_tx;

    // reset in the middle of a frame
    send(60'hAAA_5555_AAAA_5555, prev_tx, 1'b0);
    n = 0;
    while (edge_cnt < 30 && n < LAT) begin
      @(negedge clk);
      n++;
    end
    check_int("reached_bit30", int'(edge_cnt >= 30), 1);
    reset_n = 1'b0;
    #1;
    check_int("midrst_csb", int'(SPI_CSB), 1);
    check_int("midrst_sclk", int'(SPI_CLK), 0);
    check_int("midrst_busy", int'(busy), 0);
    check_int("midrst_done", int'(done), 0);
    check("midrst_rx_data", rx_data, '0);
    exp_q.delete();
    txq.delete();
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    send(60'h0C0_FFEE_1234_0042, '0, 1'b0);
    wait_done();
    @(negedge clk);
    send(60'h777_0000_7777_0000, 60'h0C0_FFEE_1234_0042, 1'b0);
    wait_done();
    repeat (10) @(negedge clk);

    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
